// File: rtl/led_fade_sequencer_pkg.sv
// Shared types, constants and saturating duty helpers for the LED fade sequencer.
package led_fade_sequencer_pkg;

  localparam int NUM_LEDS = 8;
  localparam int IDX_W    = $clog2(NUM_LEDS);
  localparam int DUTY_W   = 8;
  localparam logic [DUTY_W-1:0] DUTY_MAX = 8'd255;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    FADE_IN  = 3'd1,
    HOLD     = 3'd2,
    FADE_OUT = 3'd3,
    NEXT     = 3'd4
  } state_e;

  // Add with one extra bit of headroom, clamp to full duty on carry-out.
  function automatic logic [DUTY_W-1:0] sat_up(input logic [DUTY_W-1:0] d,
                                               input logic [DUTY_W:0]   s);
    logic [DUTY_W:0] t;
    t = {1'b0, d} + s;
    return t[DUTY_W] ? DUTY_MAX : t[DUTY_W-1:0];
  endfunction

  // Subtract with one extra bit; a borrow into the top bit means it went negative.
  function automatic logic [DUTY_W-1:0] sat_dn(input logic [DUTY_W-1:0] d,
                                               input logic [DUTY_W:0]   s);
    logic [DUTY_W:0] t;
    t = {1'b0, d} - s;
    return t[DUTY_W] ? '0 : t[DUTY_W-1:0];
  endfunction

endpackage

// File: rtl/led_fade_sequencer_tick_gen.sv
// Free-running prescaler; tick pulses for one cycle whenever the counter is all-ones.
module tick_gen #(
  parameter int N = 6
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  logic [N-1:0] cnt_q;

  // Wrapping counter, cleared asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_q + N'(1);
  end

  assign tick = &cnt_q;

endmodule

// File: rtl/led_fade_sequencer.sv
// Breathing chaser: one LED at a time ramps up, holds, ramps down, then the
// active index steps in the selected direction.
module led_fade_sequencer
  import led_fade_sequencer_pkg::*;
#(
  parameter int PRESC_N    = 6,
  parameter int STEP_N     = 18,
  parameter int STEP       = 8,
  parameter int HOLD_STEPS = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                dir,
  output logic [NUM_LEDS-1:0] ledb,
  output logic [IDX_W-1:0]    active_idx,
  output logic                busy
);

  localparam int HOLD_W = (HOLD_STEPS > 1) ? $clog2(HOLD_STEPS) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_STEPS - 1);
  localparam logic [DUTY_W:0]   STEP9     = (DUTY_W + 1)'(STEP);

  state_e              state_q, state_d;
  logic [DUTY_W-1:0]   duty_q, duty_d;
  logic [DUTY_W-1:0]   pwm_cnt_q;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [HOLD_W-1:0]   hold_q, hold_d;
  logic [NUM_LEDS-1:0] ledb_q, ledb_d;
  logic                pwm_tick, step_tick;

  tick_gen #(.N(PRESC_N)) u_pwm_presc (.clk(clk), .rst(rst), .tick(pwm_tick));
  tick_gen #(.N(STEP_N))  u_step_presc (.clk(clk), .rst(rst), .tick(step_tick));

  // FSM, duty, index, hold counter, PWM counter and LED outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      duty_q    <= '0;
      idx_q     <= '0;
      hold_q    <= '0;
      pwm_cnt_q <= '0;
      ledb_q    <= '0;
    end else begin
      state_q <= state_d;
      duty_q  <= duty_d;
      idx_q   <= idx_d;
      hold_q  <= hold_d;
      ledb_q  <= ledb_d;
      if (pwm_tick) pwm_cnt_q <= pwm_cnt_q + 8'd1;
    end
  end

  // Next state; everything holds except on a step tick, so en/dir between ticks are ignored.
  always_comb begin
    state_d = state_q;
    duty_d  = duty_q;
    idx_d   = idx_q;
    hold_d  = hold_q;
    if (step_tick) begin
      case (state_q)
        IDLE: begin
          duty_d = '0;
          if (en) state_d = FADE_IN;
        end
        FADE_IN: begin
          duty_d = sat_up(duty_q, STEP9);
          if (duty_d == DUTY_MAX) begin
            hold_d  = '0;
            state_d = HOLD;
          end
        end
        HOLD: begin
          hold_d = hold_q + HOLD_W'(1);
          if (hold_q == HOLD_LAST) state_d = FADE_OUT;
        end
        FADE_OUT: begin
          duty_d = sat_dn(duty_q, STEP9);
          if (duty_d == '0) state_d = NEXT;
        end
        NEXT: begin
          idx_d   = dir ? idx_q - IDX_W'(1) : idx_q + IDX_W'(1);
          state_d = en ? FADE_IN : IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Only the active LED compares against the duty; the rest stay dark.
  always_comb begin
    ledb_d = '0;
    for (int i = 0; i < NUM_LEDS; i++)
      ledb_d[i] = (idx_q == IDX_W'(i)) && (pwm_cnt_q < duty_q);
  end

  assign ledb       = ledb_q;
  assign active_idx = idx_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_led_fade_sequencer.sv
// Randomized and directed checks of three sequencer configurations against a
// cycle-level arithmetic model of the fade rules.
module tb_led_fade_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en_a = 1'b0, dir_a = 1'b0, en_c = 1'b0, dir_c = 1'b0;
  logic [7:0] ledb_a, ledb_b, ledb_c;
  logic [2:0] idx_a, idx_b, idx_c;
  logic       busy_a, busy_b, busy_c;

  int n_pass = 0;
  int n_tot  = 0;

  // A: main config, B: full-step single-hold, C: slow steps for PWM ratio
  led_fade_sequencer #(.PRESC_N(2), .STEP_N(3), .STEP(64), .HOLD_STEPS(2)) dut_a (
    .clk(clk), .rst(rst), .en(en_a), .dir(dir_a),
    .ledb(ledb_a), .active_idx(idx_a), .busy(busy_a));
  led_fade_sequencer #(.PRESC_N(2), .STEP_N(3), .STEP(255), .HOLD_STEPS(1)) dut_b (
    .clk(clk), .rst(rst), .en(en_a), .dir(dir_a),
    .ledb(ledb_b), .active_idx(idx_b), .busy(busy_b));
  led_fade_sequencer #(.PRESC_N(2), .STEP_N(12), .STEP(64), .HOLD_STEPS(2)) dut_c (
    .clk(clk), .rst(rst), .en(en_c), .dir(dir_c),
    .ledb(ledb_c), .active_idx(idx_c), .busy(busy_c));

  always #5 clk = ~clk;

  // Model phases: 0 idle, 1 rising, 2 holding, 3 falling, 4 advancing
  typedef struct {
    int         ph;
    int         duty;
    int         idx;
    int         held;
    int         pcnt;
    int         cyc;
    bit         stk;
    logic [7:0] led;
  } mdl_t;

  mdl_t mA, mB, mC;

  function automatic mdl_t mreset();
    mdl_t m;
    m.ph = 0; m.duty = 0; m.idx = 0; m.held = 0; m.pcnt = 0; m.cyc = 0;
    m.stk = 1'b0; m.led = '0;
    return m;
  endfunction

  function automatic mdl_t mstep(mdl_t m, bit en, bit dir, int pn, int sn, int stp, int hs);
    mdl_t n;
    bit   pt, st;
    n  = m;
    pt = (m.cyc % (1 << pn)) == (1 << pn) - 1;
    st = (m.cyc % (1 << sn)) == (1 << sn) - 1;
    for (int i = 0; i < 8; i++) n.led[i] = (i == m.idx && m.pcnt < m.duty) ? 1'b1 : 1'b0;
    if (pt) n.pcnt = (m.pcnt + 1) % 256;
    n.stk = st;
    if (st) begin
      case (m.ph)
        0: begin n.duty = 0; if (en) n.ph = 1; end
        1: begin
          n.duty = (m.duty + stp > 255) ? 255 : m.duty + stp;
          if (n.duty == 255) begin n.held = 0; n.ph = 2; end
        end
        2: begin n.held = m.held + 1; if (n.held == hs) n.ph = 3; end
        3: begin
          n.duty = (m.duty - stp < 0) ? 0 : m.duty - stp;
          if (n.duty == 0) n.ph = 4;
        end
        default: begin
          n.idx = (m.idx + (dir ? 7 : 1)) % 8;
          n.ph  = en ? 1 : 0;
        end
      endcase
    end
    n.cyc = m.cyc + 1;
    return n;
  endfunction

  task automatic chk(input string tag, input int obs, input int exp);
    n_tot++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
  endtask

  // One clock: advance the models at the edge, compare all instances 1ns later.
  task automatic tick_cycle();
    @(posedge clk);
    if (rst) begin
      mA = mreset(); mB = mreset(); mC = mreset();
    end else begin
      mA = mstep(mA, en_a, dir_a, 2, 3, 64, 2);
      mB = mstep(mB, en_a, dir_a, 2, 3, 255, 1);
      mC = mstep(mC, en_c, dir_c, 2, 12, 64, 2);
    end
    #1;
    chk("a_ledb", ledb_a, mA.led); chk("a_busy", busy_a, mA.ph != 0);
    chk("a_idx", idx_a, mA.idx);   chk("a_duty", dut_a.duty_q, mA.duty);
    chk("b_ledb", ledb_b, mB.led); chk("b_busy", busy_b, mB.ph != 0);
    chk("b_idx", idx_b, mB.idx);   chk("b_duty", dut_b.duty_q, mB.duty);
    chk("c_ledb", ledb_c, mC.led); chk("c_busy", busy_c, mC.ph != 0);
    chk("c_idx", idx_c, mC.idx);   chk("c_duty", dut_c.duty_q, mC.duty);
  endtask

  // Assert reset between edges, then release after two clocks.
  task automatic do_reset();
    #2 rst = 1'b1;
    mA = mreset(); mB = mreset(); mC = mreset();
    repeat (2) tick_cycle();
    rst = 1'b0;
  endtask

  int qa[$], qb[$], qi[$];
  int exp_a[13] = '{0, 64, 128, 192, 255, 255, 255, 191, 127, 63, 0, 0, 64};
  int exp_b[6]  = '{0, 255, 255, 0, 0, 255};
  int guard, on_cnt;

  initial begin
    mA = mreset(); mB = mreset(); mC = mreset();
    repeat (3) tick_cycle();
    rst = 1'b0;
    chk("rst_ledb", ledb_a, 0); chk("rst_busy", busy_a, 0); chk("rst_idx", idx_a, 0);

    // Idle with en low
    repeat (4096) begin
      tick_cycle();
      chk("idle_ledb", ledb_a, 0); chk("idle_busy", busy_a, 0);
    end

    // Fade profile on A and B, sampled after each step tick
    en_a = 1'b1; dir_a = 1'b0;
    guard = 0;
    while (qa.size() < 13 && guard < 400) begin
      tick_cycle(); guard++;
      if (mA.stk) begin qa.push_back(dut_a.duty_q); qb.push_back(dut_b.duty_q); qi.push_back(idx_a); end
    end
    chk("prof_len", qa.size(), 13);
    for (int i = 0; i < qa.size() && i < 13; i++) chk($sformatf("prof_a%0d", i), qa[i], exp_a[i]);
    for (int i = 0; i < qb.size() && i < 6; i++)  chk($sformatf("prof_b%0d", i), qb[i], exp_b[i]);
    if (qi.size() >= 12) begin chk("prof_idx10", qi[10], 0); chk("prof_idx11", qi[11], 1); end

    // Async reset mid-HOLD at index 3
    guard = 0;
    while (!(mA.ph == 2 && mA.idx == 3) && guard < 2000) begin tick_cycle(); guard++; end
    chk("reach_hold3", idx_a, 3);
    #2 rst = 1'b1;
    #1;
    chk("arst_ledb", ledb_a, 0); chk("arst_busy", busy_a, 0); chk("arst_idx", idx_a, 0);
    en_a = 1'b0;
    mA = mreset(); mB = mreset(); mC = mreset();
    repeat (2) tick_cycle();
    rst = 1'b0;
    repeat (64) begin tick_cycle(); chk("post_rst_busy", busy_a, 0); end

    // Wrap both ways
    en_a = 1'b1; dir_a = 1'b1;
    guard = 0;
    while (idx_a == 3'd0 && guard < 300) begin tick_cycle(); guard++; end
    chk("wrap_down", idx_a, 7);
    dir_a = 1'b0;
    guard = 0;
    while (idx_a == 3'd7 && guard < 300) begin tick_cycle(); guard++; end
    chk("wrap_up", idx_a, 0);

    // Graceful stop: drop en at duty 128 while rising
    do_reset();
    en_a = 1'b1; dir_a = 1'b0;
    guard = 0;
    while (!(mA.ph == 1 && mA.duty == 128) && guard < 300) begin tick_cycle(); guard++; end
    chk("stop_at128", dut_a.duty_q, 128);
    en_a = 1'b0;
    guard = 0;
    while (busy_a && guard < 300) begin tick_cycle(); guard++; end
    chk("stop_busy", busy_a, 0); chk("stop_idx", idx_a, 1);
    tick_cycle();
    chk("stop_ledb", ledb_a, 0); chk("stop_duty", dut_a.duty_q, 0);

    // PWM ratio on C with duty frozen at 64
    do_reset();
    en_c = 1'b1; dir_c = 1'b0;
    guard = 0;
    while (dut_c.duty_q != 8'd64 && guard < 10000) begin tick_cycle(); guard++; end
    chk("pwm_duty64", dut_c.duty_q, 64);
    on_cnt = 0;
    repeat (1024) begin
      tick_cycle();
      on_cnt += ledb_c[idx_c];
      chk("pwm_others", ledb_c & ~(8'b1 << idx_c), 0);
    end
    chk("pwm_ratio", on_cnt, 256);

    // Random en/dir activity checked cycle by cycle against the model
    do_reset();
    repeat (6000) begin
      tick_cycle();
      if ($urandom_range(0, 59) == 0) en_a = ~en_a;
      if ($urandom_range(0, 29) == 0) dir_a = ~dir_a;
      if ($urandom_range(0, 999) == 0) en_c = ~en_c;
      if ($urandom_range(0, 99) == 0) dir_c = ~dir_c;
    end

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
